led_frame_ctrl: RTL

//  Parametrised successor to the fixed 16-column LED-array top logic. Sits between rxuart and writepixels.

---
 rtl/led_disp_pkg.sv | 22 ++
 rtl/led_tick_gen.sv | 27 ++
 rtl/led_frame_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/led_disp_pkg.sv
// Shared constants and FSM state types for the LED frame controller.
// Display command/address encodings match the writepixels byte protocol.
package led_disp_pkg;

  localparam logic [7:0] CMD_DISPLAY_ON = 8'h88;
  localparam logic [7:0] ADDR_BASE      = 8'hC0;
  localparam logic [7:0] POS_CTRL       = 8'hFF;

  typedef enum logic [1:0] {
    R_IDLE,
    R_CMD,
    R_SETTLE,
    R_COL
  } refresh_state_t;

  typedef enum logic [1:0] {
    L_IDLE,
    L_FRAME,
    L_BRIGHT
  } load_state_t;

endpackage

// File: rtl/led_tick_gen.sv
// Free-running divider: one-cycle tick every PERIOD clocks, registered output.
// Counts 0..PERIOD-1; tick is asserted the cycle after the wrap value is seen.
module led_tick_gen #(
  parameter int PERIOD = 1_200_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_frame_ctrl.sv
// UART command loader into a double-buffered frame store, plus periodic refresh of the
// front buffer to writepixels over a valid/busy handshake; buffers swap only between passes.
module led_frame_ctrl
  import led_disp_pkg::*;
#(
  parameter int         CLK_HZ         = 12_000_000,
  parameter int         REFRESH_HZ     = 10,
  parameter int         NUM_COLS       = 16,
  parameter int         SETTLE_CYCLES  = CLK_HZ / 1000,
  parameter int         TIMEOUT_CYCLES = CLK_HZ / 100,
  parameter logic [7:0] FRAME_CHAR     = 8'h41,
  parameter logic [7:0] BRIGHT_CHAR    = 8'h42
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  input  logic       i_wr_busy,
  output logic       o_wr_valid,
  output logic [7:0] o_wr_pos,
  output logic [7:0] o_wr_data,
  output logic       o_frame_done,
  output logic       o_rx_err,
  output logic       o_overrun
);

  localparam int IW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] LAST_COL   = IW'(NUM_COLS - 1);
  localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_END    = TW'(TIMEOUT_CYCLES - 1);

  logic tick;

  led_tick_gen #(.PERIOD(CLK_HZ / REFRESH_HZ)) u_tick (
    .clk  (CLK),
    .rst  (RST),
    .tick (tick)
  );

  logic [7:0] front [NUM_COLS];
  logic [7:0] back  [NUM_COLS];
  logic [2:0] brightness;
  logic       swap_pending;

  // ---------------- refresh side ----------------
  refresh_state_t r_state, r_next;
  logic [IW-1:0]  col;
  logic [SW-1:0]  settle_cnt;
  logic           can_send, settle_done;
  logic           send_cmd, send_col, do_swap, pass_end;

  assign can_send    = !i_wr_busy && !o_wr_valid;
  assign settle_done = (settle_cnt == SETTLE_END);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:   if (tick) r_next = R_CMD;
      R_CMD:    if (can_send) r_next = R_SETTLE;
      R_SETTLE: if (settle_done) r_next = R_COL;
      R_COL:    if (can_send && col == LAST_COL) r_next = R_IDLE;
      default:  r_next = R_IDLE;
    endcase
  end

  always_comb begin
    send_cmd = (r_state == R_CMD) && can_send;
    send_col = (r_state == R_COL) && can_send;
    do_swap  = (r_state == R_IDLE) && tick && swap_pending;
    pass_end = send_col && (col == LAST_COL);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      o_wr_valid   <= 1'b0;
      o_wr_pos     <= '0;
      o_wr_data    <= '0;
      o_frame_done <= 1'b0;
      o_overrun    <= 1'b0;
      col          <= '0;
      settle_cnt   <= '0;
      for (int i = 0; i < NUM_COLS; i++) front[i] <= '0;
    end else begin
      o_wr_valid   <= send_cmd || send_col;
      o_frame_done <= pass_end;
      o_overrun    <= tick && (r_state != R_IDLE);
      if (send_cmd) begin
        o_wr_pos  <= POS_CTRL;
        o_wr_data <= CMD_DISPLAY_ON | {5'b0, brightness};
      end else if (send_col) begin
        o_wr_pos  <= ADDR_BASE + 8'(col);
        o_wr_data <= front[col];
      end
      if (r_state != R_COL) col <= '0;
      else if (send_col)    col <= col + 1'b1;
      if (r_state == R_SETTLE) settle_cnt <= settle_cnt + 1'b1;
      else                     settle_cnt <= '0;
      // Front only changes from R_IDLE, so a pass never mixes two frames.
      if (do_swap)
        for (int i = 0; i < NUM_COLS; i++) front[i] <= back[i];
    end
  end

  // ---------------- loader side ----------------
  load_state_t   l_state, l_next;
  logic [IW-1:0] idx;
  logic [TW-1:0] gap_cnt;
  logic          timeout, wr_back, set_swap, set_bright;

  assign timeout = (l_state != L_IDLE) && !i_rx_valid && (gap_cnt == GAP_END);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) l_state <= L_IDLE;
    else     l_state <= l_next;
  end

  always_comb begin
    l_next = l_state;
    case (l_state)
      L_IDLE: begin
        if (i_rx_valid && i_rx_data == FRAME_CHAR && !swap_pending) l_next = L_FRAME;
        else if (i_rx_valid && i_rx_data == BRIGHT_CHAR)            l_next = L_BRIGHT;
      end
      L_FRAME:  if ((i_rx_valid && idx == LAST_COL) || timeout) l_next = L_IDLE;
      L_BRIGHT: if (i_rx_valid || timeout) l_next = L_IDLE;
      default:  l_next = L_IDLE;
    endcase
  end

  always_comb begin
    wr_back    = (l_state == L_FRAME) && i_rx_valid;
    set_swap   = wr_back && (idx == LAST_COL);
    set_bright = (l_state == L_BRIGHT) && i_rx_valid;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx          <= '0;
      gap_cnt      <= '0;
      brightness   <= 3'd1;
      swap_pending <= 1'b0;
      o_rx_err     <= 1'b0;
      for (int i = 0; i < NUM_COLS; i++) back[i] <= '0;
    end else begin
      o_rx_err <= timeout;
      if (l_state != L_FRAME) idx <= '0;
      else if (wr_back)       idx <= idx + 1'b1;
      if (l_state == L_IDLE || i_rx_valid) gap_cnt <= '0;
      else                                 gap_cnt <= gap_cnt + 1'b1;
      if (wr_back)    back[idx]  <= i_rx_data;
      if (set_bright) brightness <= i_rx_data[2:0];
      // set and clear never coincide: a load only starts while nothing is pending
      if (set_swap)     swap_pending <= 1'b1;
      else if (do_swap) swap_pending <= 1'b0;
    end
  end

endmodule
